// File: rtl/hazard_if.sv
// Pipeline-side bundle for the hazard detector: stage register/opcode info in,
// stall/flush/interrupt requests out toward the pipeline controller.
interface hazard_if;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_rs1_used;
  logic       id_rs2_used;
  logic [4:0] exe_rd;
  logic       exe_mem_read;
  logic       exe_branch_taken;
  logic       exe_is_div;
  logic       mem_mret;
  logic       stall_pipl;
  logic       irq_req;
  logic       load_hazard;
  logic       branch_hazard;
  logic       divide_stall;
  logic       mret_type;
  logic       interrupt;
  logic       irq_ack;

  // Requests are level signals evaluated every cycle; there is no valid/ready
  // pairing here. The controller acts on a request in the cycle it is high.
  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used, exe_rd, exe_mem_read,
           exe_branch_taken, exe_is_div, mem_mret, stall_pipl, irq_req,
    input  load_hazard, branch_hazard, divide_stall, mret_type, interrupt, irq_ack
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, exe_rd, exe_mem_read,
           exe_branch_taken, exe_is_div, mem_mret, stall_pipl, irq_req,
    output load_hazard, branch_hazard, divide_stall, mret_type, interrupt, irq_ack
  );
endinterface

// File: rtl/hazard_detector.sv
// Load-use / redirect / divide-stall / mret / interrupt request generation,
// including divide sequencing and interrupt holdoff arbitration.
module hazard_detector #(
  parameter int DIV_LATENCY = 32,
  parameter int IRQ_HOLDOFF = 2
) (
  input  logic       clk,
  input  logic       reset,
  hazard_if.slave    hz,
  output logic [1:0] div_state
);

  localparam int CW = $clog2(DIV_LATENCY);
  localparam int HW = $clog2(IRQ_HOLDOFF + 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_LATENCY - 2);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(IRQ_HOLDOFF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  div_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [HW-1:0] holdoff_q;
  logic          ack_q;
  logic          rst_d_q;
  logic          quiet;
  logic          src_hit;
  logic          div_stall_raw;
  logic          irq_ok;

  // Outputs are forced low during reset and for one cycle after it falls.
  assign quiet = reset | rst_d_q;

  always_ff @(posedge clk) begin
    rst_d_q <= reset;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else if (!rst_d_q) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; the counter runs regardless of bus stalls.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (hz.exe_is_div) begin
          state_d = BUSY;
          cnt_d   = DIV_LOAD;
        end
      end
      BUSY: begin
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      DONE: begin
        if (!hz.stall_pipl) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    div_stall_raw = 1'b0;
    unique case (state_q)
      IDLE:    div_stall_raw = hz.exe_is_div;
      BUSY:    div_stall_raw = 1'b1;
      default: div_stall_raw = 1'b0;
    endcase
  end

  assign src_hit = (hz.id_rs1_used && (hz.id_rs1 == hz.exe_rd)) ||
                   (hz.id_rs2_used && (hz.id_rs2 == hz.exe_rd));

  assign irq_ok = hz.irq_req && (state_q == IDLE) && !hz.exe_is_div &&
                  !hz.stall_pipl && !hz.exe_branch_taken && !hz.mem_mret &&
                  (holdoff_q == '0);

  always_comb begin
    hz.load_hazard   = 1'b0;
    hz.branch_hazard = 1'b0;
    hz.divide_stall  = 1'b0;
    hz.mret_type     = 1'b0;
    hz.interrupt     = 1'b0;
    if (!quiet) begin
      hz.branch_hazard = hz.exe_branch_taken;
      hz.mret_type     = hz.mem_mret;
      // ID is flushed on a redirect, so a load-use stall would be wasted.
      hz.load_hazard   = hz.exe_mem_read && (hz.exe_rd != 5'd0) && src_hit &&
                         !hz.exe_branch_taken;
      hz.divide_stall  = div_stall_raw;
      hz.interrupt     = irq_ok;
    end
  end

  assign hz.irq_ack = ack_q & ~reset;
  assign div_state  = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      holdoff_q <= '0;
      ack_q     <= 1'b0;
    end else begin
      ack_q <= hz.interrupt;
      if (hz.interrupt || hz.mret_type) holdoff_q <= HOLD_LOAD;
      else if (holdoff_q != '0)         holdoff_q <= holdoff_q - HW'(1);
    end
  end

endmodule
